// File: rtl/cci_write_response_tracker_if.sv
// cci_write_response_tracker_if: grant/response inputs and per-client status outputs of the write tracker
interface cci_write_response_tracker_if #(
  parameter int MDATA_W = 13,
  parameter int CNT_W   = 7
);
  logic               afu_en;
  logic               writer_grant;
  logic               reader_grant;
  logic               status_grant;
  logic               rx0_wrvalid;
  logic [MDATA_W-1:0] rx0_mdata;
  logic               rx1_wrvalid;
  logic [MDATA_W-1:0] rx1_mdata;
  logic [1:0]         writer_done;
  logic [1:0]         reader_done;
  logic [1:0]         status_done;
  logic [CNT_W-1:0]   writer_outstanding;
  logic [CNT_W-1:0]   reader_outstanding;
  logic [CNT_W-1:0]   status_outstanding;
  logic               writer_room;
  logic               reader_room;
  logic               status_room;
  logic               idle;
  logic [2:0]         err;
  modport slave (
    input  afu_en, writer_grant, reader_grant, status_grant,
           rx0_wrvalid, rx0_mdata, rx1_wrvalid, rx1_mdata,
    output writer_done, reader_done, status_done,
           writer_outstanding, reader_outstanding, status_outstanding,
           writer_room, reader_room, status_room, idle, err
  );
  modport master (
    output afu_en, writer_grant, reader_grant, status_grant,
           rx0_wrvalid, rx0_mdata, rx1_wrvalid, rx1_mdata,
    input  writer_done, reader_done, status_done,
           writer_outstanding, reader_outstanding, status_outstanding,
           writer_room, reader_room, status_room, idle, err
  );
endinterface

// File: rtl/cci_write_response_tracker.sv
// cci_write_response_tracker: per-client in-flight write counts, completion pulses, room/idle and sticky error flags
module cci_write_response_tracker #(
  parameter int MDATA_W         = 13,
  parameter int MAX_OUTSTANDING = 64
) (
  input logic                      clk,
  input logic                      resetb,
  cci_write_response_tracker_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW    = CNT_W + 1;
  logic [1:0]       id0, id1;
  logic [2:0]       grant;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [1:0]       done_q [3];
  logic [1:0]       done_d [3];
  logic [SW-1:0]    sum [3];
  logic [SW-1:0]    diff [3];
  logic [2:0]       err_q, err_d;
  assign id0   = bus.rx0_mdata[MDATA_W-1 -: 2];
  assign id1   = bus.rx1_mdata[MDATA_W-1 -: 2];
  assign grant = {bus.status_grant, bus.reader_grant, bus.writer_grant};
  // client k: 0 writer, 1 reader, 2 status; ID 3 is never a client
  always_comb begin
    err_d    = err_q;
    err_d[2] = err_q[2] | (bus.rx0_wrvalid && id0 == 2'd3) | (bus.rx1_wrvalid && id1 == 2'd3);
    for (int k = 0; k < 3; k++) begin
      done_d[k] = 2'(bus.rx0_wrvalid && id0 == 2'(k)) + 2'(bus.rx1_wrvalid && id1 == 2'(k));
      sum[k]    = {1'b0, cnt_q[k]} + SW'(grant[k]);
      diff[k]   = sum[k] - SW'(done_d[k]);
      cnt_d[k]  = CNT_W'(diff[k]);
      if (sum[k] < SW'(done_d[k])) begin
        err_d[0] = 1'b1;
        cnt_d[k] = '0;
      end else if (diff[k] > SW'(MAX_OUTSTANDING)) begin
        err_d[1] = 1'b1;
        cnt_d[k] = CNT_W'(MAX_OUTSTANDING);
      end
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q  <= '{default: '0};
      done_q <= '{default: '0};
      err_q  <= '0;
    end else if (!bus.afu_en) begin
      cnt_q  <= '{default: '0};
      done_q <= '{default: '0};
      err_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end
  assign bus.writer_done        = done_q[0];
  assign bus.reader_done        = done_q[1];
  assign bus.status_done        = done_q[2];
  assign bus.writer_outstanding = cnt_q[0];
  assign bus.reader_outstanding = cnt_q[1];
  assign bus.status_outstanding = cnt_q[2];
  assign bus.writer_room        = cnt_q[0] < CNT_W'(MAX_OUTSTANDING);
  assign bus.reader_room        = cnt_q[1] < CNT_W'(MAX_OUTSTANDING);
  assign bus.status_room        = cnt_q[2] < CNT_W'(MAX_OUTSTANDING);
  assign bus.idle               = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (cnt_q[2] == '0);
  assign bus.err                = err_q;
endmodule

// File: tb/tb_cci_write_response_tracker.sv
// tb_cci_write_response_tracker: directed scenarios plus random traffic checked against an integer reference model
module tb_cci_write_response_tracker;
  localparam int MDATA_W = 13;
  localparam int MAXO    = 4;
  localparam int CNT_W   = $clog2(MAXO + 1);
  logic clk, resetb;
  int   n_chk, n_err;
  int   m_cnt [3];
  int   m_done [3];
  int   m_err;
  int   g_s, i0_s, i1_s;
  bit   v0_s, v1_s, en_s;
  cci_write_response_tracker_if #(.MDATA_W(MDATA_W), .CNT_W(CNT_W)) bus ();
  cci_write_response_tracker #(.MDATA_W(MDATA_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if ($countones({bus.writer_grant, bus.reader_grant, bus.status_grant}) > 1) begin
      $display("multiple grants in one cycle");
      $finish;
    end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_done[k] = 0;
    end
    m_err = 0;
  endtask
  task automatic model_step();
    int r, n;
    if (!en_s) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      r = int'(v0_s && i0_s == k) + int'(v1_s && i1_s == k);
      n = m_cnt[k] + int'(g_s == k + 1) - r;
      if (n < 0) begin m_err |= 1; n = 0; end
      if (n > MAXO) begin m_err |= 2; n = MAXO; end
      m_cnt[k]  = n;
      m_done[k] = r;
    end
    if ((v0_s && i0_s == 3) || (v1_s && i1_s == 3)) m_err |= 4;
  endtask
  task automatic check_all();
    chk("w_done", bus.writer_done, m_done[0]);
    chk("r_done", bus.reader_done, m_done[1]);
    chk("s_done", bus.status_done, m_done[2]);
    chk("w_cnt", bus.writer_outstanding, m_cnt[0]);
    chk("r_cnt", bus.reader_outstanding, m_cnt[1]);
    chk("s_cnt", bus.status_outstanding, m_cnt[2]);
    chk("w_room", bus.writer_room, int'(m_cnt[0] < MAXO));
    chk("r_room", bus.reader_room, int'(m_cnt[1] < MAXO));
    chk("s_room", bus.status_room, int'(m_cnt[2] < MAXO));
    chk("idle", bus.idle, int'(m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0));
    chk("err", bus.err, m_err);
  endtask
  task automatic cyc(input int g, input bit v0, input int i0, input bit v1, input int i1, input bit en = 1);
    g_s = g; v0_s = v0; i0_s = i0; v1_s = v1; i1_s = i1; en_s = en;
    bus.afu_en       = en;
    bus.writer_grant = (g == 1);
    bus.reader_grant = (g == 2);
    bus.status_grant = (g == 3);
    bus.rx0_wrvalid  = v0;
    bus.rx1_wrvalid  = v1;
    bus.rx0_mdata    = {2'(i0), 11'($urandom)};
    bus.rx1_mdata    = {2'(i1), 11'($urandom)};
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  initial begin
    n_chk = 0; n_err = 0;
    resetb = 0;
    bus.afu_en = 1; bus.writer_grant = 0; bus.reader_grant = 0; bus.status_grant = 0;
    bus.rx0_wrvalid = 0; bus.rx1_wrvalid = 0; bus.rx0_mdata = '0; bus.rx1_mdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) resetb = 1;
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("t1_cnt3", bus.writer_outstanding, 3);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("t1_idle", bus.idle, 1);
    repeat (4) cyc(2, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1);
    chk("t2_done2", bus.reader_done, 2);
    chk("t2_cnt", bus.reader_outstanding, 2);
    cyc(0, 1, 1, 1, 1);
    cyc(3, 0, 0, 0, 0);
    cyc(3, 1, 2, 0, 0);
    chk("t3_cnt", bus.status_outstanding, 1);
    chk("t3_done", bus.status_done, 1);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("t4_room_pre", bus.writer_room, 1);
    cyc(1, 0, 0, 0, 0);
    chk("t4_room", bus.writer_room, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t4_ovf", bus.err, 2);
    chk("t4_hold", bus.writer_outstanding, 4);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3);
    chk("t5_bad", bus.err, 4);
    cyc(0, 1, 0, 0, 0);
    chk("t5_unf", bus.err, 5);
    chk("t5_wdone", bus.writer_done, 1);
    cyc(2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_clr_idle", bus.idle, 1);
    cyc(3, 1, 3, 0, 0);
    #2 resetb = 0;
    #1 model_clear();
    check_all();
    @(negedge clk) resetb = 1;
    for (int n = 0; n < 500; n++)
      cyc($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 39) != 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
